// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: pins are oversampled in the clk domain, MSB-first
// WORD_W-bit frames are assembled and queued in a small FIFO with a valid/ready read side.
module spi_frame_rx #(
    parameter int WORD_W      = 24,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk_in,
    input  logic                   cs_n_in,
    input  logic                   mosi_in,
    output logic [WORD_W-1:0]      word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   frame_err,
    output logic                   err_len,
    output logic                   err_ovf,
    input  logic                   err_clr
);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, cs_hist_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   push, discard;

    logic [WORD_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic                   pop, push_ok, ovf_drop;
    logic                   frame_err_q, frame_err_d;
    logic                   err_len_q, err_len_d, err_ovf_q, err_ovf_d;

    // cs_n resets high so an idle bus never looks like a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // A cs_n rise takes priority over an sclk rise seen in the same cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        discard = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(WORD_W)) push = 1'b1;
                    else                          discard = 1'b1;
                end else if (sclk_rise) begin
                    if (cnt_q == CNT_W'(WORD_W)) begin
                        state_d = OVERRUN;
                    end else begin
                        shreg_d = {shreg_q[WORD_W-2:0], mosi_s};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            OVERRUN: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    discard = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    always_comb begin
        pop         = (count_q != '0) && word_ready;
        push_ok     = push && ((count_q < LVL_W'(DEPTH)) || pop);
        ovf_drop    = push && !push_ok;
        count_d     = count_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (push_ok && !pop)      count_d = count_q + LVL_W'(1);
        else if (!push_ok && pop) count_d = count_q - LVL_W'(1);
        frame_err_d = discard | ovf_drop;
        err_len_d   = discard  ? 1'b1 : (err_clr ? 1'b0 : err_len_q);
        err_ovf_d   = ovf_drop ? 1'b1 : (err_clr ? 1'b0 : err_ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            err_len_q   <= err_len_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign word_valid = (count_q != '0);
    assign word_out   = word_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = count_q;
    assign frame_err  = frame_err_q;
    assign err_len    = err_len_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: bit-banged SPI frames with hand-computed
// expected words, error flags and FIFO levels.
module tb_spi_frame_rx;

    logic        clk = 1'b0;
    logic        rst, sclkIn, csNIn, mosiIn, wordReady, errClr;
    logic [23:0] wordOut;
    logic        wordValid, frameErr, errLen, errOvf;
    logic [2:0]  fifoLevel;

    int          vectors = 0;
    int          miscompares = 0;
    int          errCycles = 0;
    int          validCycles = 0;
    logic [23:0] popQ [$];

    spi_frame_rx #(.WORD_W(24), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclkIn), .cs_n_in(csNIn), .mosi_in(mosiIn),
        .word_out(wordOut), .word_valid(wordValid), .word_ready(wordReady),
        .fifo_level(fifoLevel), .frame_err(frameErr), .err_len(errLen),
        .err_ovf(errOvf), .err_clr(errClr)
    );

    always #5 clk = ~clk;

    // Records every accepted word and every cycle frame_err / word_valid is high.
    always @(negedge clk) begin
        if (wordValid && wordReady) popQ.push_back(wordOut);
        if (frameErr) errCycles++;
        if (wordValid) validCycles++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clearMonitors();
        popQ.delete();
        errCycles   = 0;
        validCycles = 0;
    endtask

    task automatic spiStart();
        csNIn = 1'b0;
        waitClks(4);
    endtask

    task automatic spiBits(input logic [31:0] value, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosiIn = value[i];
            waitClks(4);
            sclkIn = 1'b1;
            waitClks(4);
            sclkIn = 1'b0;
        end
    endtask

    task automatic spiEnd();
        waitClks(4);
        csNIn = 1'b1;
        waitClks(6);
    endtask

    task automatic spiFrame(input logic [31:0] value, input int n);
        spiStart();
        spiBits(value, n);
        spiEnd();
    endtask

    task automatic pulseErrClr();
        errClr = 1'b1;
        waitClks(1);
        errClr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sclkIn = 1'b0; csNIn = 1'b1; mosiIn = 1'b0;
        wordReady = 1'b0; errClr = 1'b0;
        waitClks(3);
        rst = 1'b0;
        waitClks(3);
        @(negedge clk);
        vectors += 6;
        if (wordOut !== 24'h0) begin miscompares++; $display("[TB] FAIL reset word_out: got %h want 000000", wordOut); end
        if (wordValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset word_valid: got %b want 0", wordValid); end
        if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL reset fifo_level: got %0d want 0", fifoLevel); end
        if (frameErr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset frame_err: got %b want 0", frameErr); end
        if (errLen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset err_len: got %b want 0", errLen); end
        if (errOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset err_ovf: got %b want 0", errOvf); end
    endtask

    task automatic test_single_frame();
        int lat = -1;
        wordReady = 1'b1;
        clearMonitors();
        spiStart();
        spiBits(32'h2A0F35, 24);
        waitClks(4);
        csNIn = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wordValid && lat < 0) lat = i;
        end
        waitClks(2);
        @(negedge clk);
        vectors += 7;
        if (lat !== 2) begin miscompares++; $display("[TB] FAIL single latency: got %0d want 2", lat); end
        if (popQ.size() !== 1) begin miscompares++; $display("[TB] FAIL single pop count: got %0d want 1", popQ.size()); end
        else if (popQ[0] !== 24'h2A0F35) begin miscompares++; $display("[TB] FAIL single word: got %h want 2a0f35", popQ[0]); end
        if (validCycles !== 1) begin miscompares++; $display("[TB] FAIL single valid cycles: got %0d want 1", validCycles); end
        if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL single fifo_level: got %0d want 0", fifoLevel); end
        if (errCycles !== 0) begin miscompares++; $display("[TB] FAIL single frame_err cycles: got %0d want 0", errCycles); end
        if ({errLen, errOvf} !== 2'b00) begin miscompares++; $display("[TB] FAIL single sticky: got %b want 00", {errLen, errOvf}); end
    endtask

    task automatic test_bad_length();
        wordReady = 1'b1;
        clearMonitors();
        spiFrame(32'h7FFFFF, 23);
        spiFrame(32'h1555555, 25);
        @(negedge clk);
        vectors += 5;
        if (errCycles !== 2) begin miscompares++; $display("[TB] FAIL length frame_err cycles: got %0d want 2", errCycles); end
        if (errLen !== 1'b1) begin miscompares++; $display("[TB] FAIL length err_len: got %b want 1", errLen); end
        if (errOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL length err_ovf: got %b want 0", errOvf); end
        if (popQ.size() !== 0) begin miscompares++; $display("[TB] FAIL length pushed words: got %0d want 0", popQ.size()); end
        pulseErrClr();
        @(negedge clk);
        if (errLen !== 1'b0) begin miscompares++; $display("[TB] FAIL length err_clr: got %b want 0", errLen); end
    endtask

    task automatic test_overflow();
        wordReady = 1'b0;
        clearMonitors();
        for (int k = 1; k <= 5; k++) spiFrame(32'(k), 24);
        @(negedge clk);
        vectors += 6;
        if (fifoLevel !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf fifo_level: got %0d want 4", fifoLevel); end
        if (errOvf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf err_ovf: got %b want 1", errOvf); end
        if (errLen !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf err_len: got %b want 0", errLen); end
        if (errCycles !== 1) begin miscompares++; $display("[TB] FAIL ovf frame_err cycles: got %0d want 1", errCycles); end
        if (wordOut !== 24'h000001) begin miscompares++; $display("[TB] FAIL ovf head: got %h want 000001", wordOut); end
        waitClks(1);
        wordReady = 1'b1;
        waitClks(8);
        @(negedge clk);
        if (popQ.size() !== 4) begin miscompares++; $display("[TB] FAIL ovf pop count: got %0d want 4", popQ.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (popQ[k] !== 24'(k + 1)) begin
                    miscompares++;
                    $display("[TB] FAIL ovf pop order %0d: got %h want %h", k, popQ[k], 24'(k + 1));
                end
            end
        end
        pulseErrClr();
        @(negedge clk);
        vectors += 2;
        if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL ovf drained level: got %0d want 0", fifoLevel); end
        if (errOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf err_clr: got %b want 0", errOvf); end
    endtask

    task automatic test_full_with_pop();
        wordReady = 1'b0;
        clearMonitors();
        for (int k = 0; k < 4; k++) spiFrame(32'h10 + 32'(k), 24);
        spiStart();
        spiBits(32'h14, 24);
        waitClks(4);
        csNIn = 1'b1;
        waitClks(2);
        wordReady = 1'b1;
        waitClks(1);
        wordReady = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (fifoLevel !== 3'd4) begin miscompares++; $display("[TB] FAIL fullpop fifo_level: got %0d want 4", fifoLevel); end
        if (errOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpop err_ovf: got %b want 0", errOvf); end
        if (errCycles !== 0) begin miscompares++; $display("[TB] FAIL fullpop frame_err cycles: got %0d want 0", errCycles); end
        waitClks(4);
        wordReady = 1'b1;
        waitClks(8);
        @(negedge clk);
        vectors++;
        if (popQ.size() !== 5) begin miscompares++; $display("[TB] FAIL fullpop pop count: got %0d want 5", popQ.size()); end
        else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (popQ[k] !== 24'h10 + 24'(k)) begin
                    miscompares++;
                    $display("[TB] FAIL fullpop pop order %0d: got %h want %h", k, popQ[k], 24'h10 + 24'(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back_edges();
        wordReady = 1'b1;
        clearMonitors();
        spiStart();
        spiBits(32'hA5C3E1, 24);
        mosiIn = 1'b1;
        waitClks(4);
        sclkIn = 1'b1;
        csNIn  = 1'b1;
        waitClks(4);
        sclkIn = 1'b0;
        waitClks(6);
        @(negedge clk);
        vectors += 3;
        if (popQ.size() !== 1) begin miscompares++; $display("[TB] FAIL simul pop count: got %0d want 1", popQ.size()); end
        else if (popQ[0] !== 24'hA5C3E1) begin miscompares++; $display("[TB] FAIL simul word: got %h want a5c3e1", popQ[0]); end
        if (errCycles !== 0) begin miscompares++; $display("[TB] FAIL simul frame_err cycles: got %0d want 0", errCycles); end
        if (errLen !== 1'b0) begin miscompares++; $display("[TB] FAIL simul err_len: got %b want 0", errLen); end
    endtask

    task automatic test_midframe_reset();
        wordReady = 1'b0;
        spiFrame(32'h123456, 24);
        spiFrame(32'hAB, 8);
        @(negedge clk);
        vectors += 2;
        if (wordValid !== 1'b1) begin miscompares++; $display("[TB] FAIL prereset word_valid: got %b want 1", wordValid); end
        if (errLen !== 1'b1) begin miscompares++; $display("[TB] FAIL prereset err_len: got %b want 1", errLen); end
        waitClks(1);
        spiStart();
        spiBits(32'hABC, 12);
        waitClks(2);
        rst = 1'b1;
        waitClks(1);
        csNIn  = 1'b1;
        sclkIn = 1'b0;
        waitClks(3);
        rst = 1'b0;
        waitClks(5);
        @(negedge clk);
        vectors += 5;
        if (wordValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset word_valid: got %b want 0", wordValid); end
        if (wordOut !== 24'h0) begin miscompares++; $display("[TB] FAIL midreset word_out: got %h want 000000", wordOut); end
        if (fifoLevel !== 3'd0) begin miscompares++; $display("[TB] FAIL midreset fifo_level: got %0d want 0", fifoLevel); end
        if (errLen !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset err_len: got %b want 0", errLen); end
        if (frameErr !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset frame_err: got %b want 0", frameErr); end
        wordReady = 1'b1;
        clearMonitors();
        spiFrame(32'hFFFFFF, 24);
        @(negedge clk);
        vectors += 2;
        if (popQ.size() !== 1) begin miscompares++; $display("[TB] FAIL postreset pop count: got %0d want 1", popQ.size()); end
        else if (popQ[0] !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL postreset word: got %h want ffffff", popQ[0]); end
        if (errCycles !== 0) begin miscompares++; $display("[TB] FAIL postreset frame_err cycles: got %0d want 0", errCycles); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bad_length();
        test_overflow();
        test_full_with_pop();
        test_back_to_back_edges();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Serial-to-parallel front end for the SPI-driven ALU datapath. It oversamples a mode-0 SPI slave port (sclk, cs_n, mosi) in the system clock domain and assembles MSB-first 24-bit command frames. Good frames go into a small FIFO, and a valid/ready interface delivers them to the SPI controller stage downstream, which consumes the 24-bit write word. Frames of the wrong length and frames dropped on overflow are flagged.

## Interface
- WORD_W, 24, frame length in bits; the layout passes through untouched: [23:22] reserved, [21:19] dest addr, [18:16] alu sel, [15:8] operand a, [7:0] operand b
- DEPTH, 4, FIFO entries; must be a power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops on each pin input (≥2)

Ports:
- clk  in  1  system clock; every flop uses the rising edge
- rst  in  1  asynchronous, active-high reset
- sclk_in  in  1  SPI clock pin, asynchronous to clk
- cs_n_in  in  1  SPI chip select pin, active low, asynchronous
- mosi_in  in  1  SPI data pin, asynchronous
- word_out  out  WORD_W  FIFO head; 0 when the FIFO is empty
- word_valid  out  1  FIFO not empty
- word_ready  in  1  consumer accepts the head when word_valid && word_ready
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries
- frame_err  out  1  one-cycle pulse when a frame is discarded
- err_len  out  1  sticky: a frame was discarded for bad length
- err_ovf  out  1  sticky: a good frame was dropped because the FIFO was full
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- Synchronizers:
  - sclk and mosi reset to 0; cs_n resets to 1.
  - One extra history flop on synced sclk and cs_n provides edge detection: rise = s & ~d, fall = ~s & d.
- Shift state machine, with shreg[WORD_W-1:0] and cnt[$clog2(WORD_W+1)-1:0]:
  - IDLE: on cs_n fall, go to SHIFT and clear shreg and cnt.
  - SHIFT:
    - on sclk rise with cnt<WORD_W, set shreg <= {shreg[WORD_W-2:0], mosi_sync} and cnt++;
    - on sclk rise with cnt==WORD_W, go to OVERRUN.
  - OVERRUN: ignore sclk until cs_n rises.
  - Any state except IDLE, on cs_n rise, go to IDLE:
    - from SHIFT with cnt==WORD_W: push shreg;
    - otherwise (short frame, or OVERRUN): discard, pulse frame_err, set err_len.
- Simultaneous cs_n rise and sclk rise in the same cycle: the cs_n rise wins and the bit is not shifted.
- mosi is sampled from the same synchronizer depth as sclk.
- FIFO:
  - Circular buffer with rd_ptr, wr_ptr and a count.
  - A push is accepted if count<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the push is dropped: pulse frame_err and set err_ovf.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Sticky flags:
  - err_clr clears both sticky flags.
  - A set and err_clr in the same cycle: set wins.
- Reset (asynchronous, any time, including mid-frame):
  - state is IDLE; shreg, cnt and pointers are 0; FIFO is empty;
  - word_out=0, word_valid=0, fifo_level=0, frame_err=0, err_len=0, err_ovf=0.
  - If cs_n_in is held low through reset release, the synchronizer reset value of 1 produces a falling edge. The partial frame that follows ends as a length error.

## Timing
- Push-to-valid latency: let edge N be the first clk edge that samples cs_n_in high after the 24th bit.
  - Stage outputs go high at N .. N+SYNC_STAGES-1.
  - The push is registered at edge N+SYNC_STAGES.
  - word_valid rises after that edge if the FIFO was empty (edge N+2 for the default).
- Pop: word_out and word_valid update on the clock edge after the accepting cycle; there is no combinational path from ready to valid.
- frame_err is high for exactly one clock, in the cycle after the cs_n rise is registered.
- SPI constraint: each sclk high and low phase is ≥ SYNC_STAGES+1 clk periods.
  - mosi is stable from ≥ SYNC_STAGES+1 clk periods before each sclk rise until ≥1 clk period after it.
  - The cs_n high time between frames is ≥ SYNC_STAGES+2 clk periods.
- Throughput: one frame per cs_n cycle. The FIFO absorbs up to DEPTH frames while word_ready is low.

## Test plan
- Single frame 0x2A_0F_35 (addr=5, sel=2, a=0x0F, b=0x35), with word_ready=1 -> word_valid pulses one cycle, word_out=0x2A0F35, fifo_level returns to 0, no errors.
- 23-bit frame, then 25-bit frame -> two frame_err pulses, err_len=1, nothing pushed; err_clr -> err_len=0.
- word_ready=0, send 5 frames 0x000001..0x000005 -> fifo_level=4, 5th frame dropped, err_ovf=1; then ready=1 -> pops 1,2,3,4 in order, and the pointers wrap.
- FIFO full with word_ready=1 and a new frame completing in the same cycle as a pop -> push accepted, fifo_level stays 4, err_ovf stays 0.
- Assert rst after bit 12 of a frame, release with cs_n high -> all outputs reset; the next full frame 0xFFFFFF is received intact.
- cs_n rises in the same clk as the 25th sclk rise -> 24-bit word pushed, no error.
